pong_state_rx: RTL



---
 rtl/pong_link_pkg.sv | 25 ++
 rtl/pong_link_watchdog.sv | 27 ++
 rtl/pong_state_rx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pong_link_pkg.sv
// Shared definitions for the inter-board game-state link: frame constants,
// the receiver state type and the power-on values of the published fields.
package pong_link_pkg;

  localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
  localparam int unsigned FRAME_LEN    = 9;

  localparam logic [10:0] X_BALL_RST   = 11'd512;
  localparam logic [9:0]  Y_BALL_RST   = 10'd384;
  localparam logic [9:0]  Y_PLAYER_RST = 10'd334;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } rx_state_t;

  // True when the unused high bits of the three coordinate MSB bytes are zero.
  function automatic logic reserved_clear(input logic [7:0] b1,
                                          input logic [7:0] b3,
                                          input logic [7:0] b5);
    return (b1[7:3] == 5'b0) && (b3[7:2] == 6'b0) && (b5[7:2] == 6'b0);
  endfunction

endpackage

// File: rtl/pong_link_watchdog.sv
// Saturating cycle counter: counts up from zero after every restart and
// holds at LIMIT, where it reports expired until the next restart.
module pong_link_watchdog #(
  parameter int unsigned LIMIT = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] r_count;

  // Count idle cycles; clear on reset or restart, stick at LIMIT.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_count <= '0;
    end else if (r_count != W'(LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == W'(LIMIT));

endmodule

// File: rtl/pong_state_rx.sv
// Slave-side game-state frame decoder: hunts for the sync byte, collects the
// seven payload bytes into shadow registers, verifies reserved bits and the
// XOR checksum, then publishes all fields on one edge. Two watchdogs supervise
// the inter-byte gap and the age of the last accepted frame.
module pong_state_rx
  import pong_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES   = 65_000,
  parameter int unsigned LINK_LOSS_CYCLES = 6_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [10:0] x_ball,
  output logic [9:0]  y_ball,
  output logic [9:0]  y_player,
  output logic [3:0]  player1_score,
  output logic [3:0]  player2_score,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        link_up
);

  // Payload bytes B1..B7 live at shadow index 0..6.
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 3);

  rx_state_t   r_state;
  rx_state_t   w_state_next;
  logic [2:0]  r_idx;
  logic [7:0]  r_xor;
  logic [7:0]  r_shadow [0:6];
  logic        w_store;
  logic        w_accept;
  logic        w_reject;
  logic        w_frame_ok;
  logic        w_gap_restart;
  logic        w_gap_expired;
  logic        w_link_expired;

  logic [10:0] r_x_ball;
  logic [9:0]  r_y_ball;
  logic [9:0]  r_y_player;
  logic [3:0]  r_p1_score;
  logic [3:0]  r_p2_score;
  logic        r_frame_valid;
  logic        r_frame_error;
  logic        r_link_up;

  // The gap counter only runs inside a frame; every byte restarts it.
  assign w_gap_restart = rx_valid || (r_state == HUNT);

  pong_link_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_gap_wd (
    .clk     (clk),
    .rst     (rst),
    .restart (w_gap_restart),
    .expired (w_gap_expired)
  );

  pong_link_watchdog #(.LIMIT(LINK_LOSS_CYCLES)) u_link_wd (
    .clk     (clk),
    .rst     (rst),
    .restart (w_accept),
    .expired (w_link_expired)
  );

  assign w_frame_ok = (rx_data == r_xor) &&
                      reserved_clear(r_shadow[0], r_shadow[2], r_shadow[4]);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_next = r_state;
    w_store      = 1'b0;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          w_state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          w_store = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_next = CHECK;
          end
        end else if (w_gap_expired) begin
          w_reject     = 1'b1;
          w_state_next = HUNT;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          w_accept     = w_frame_ok;
          w_reject     = !w_frame_ok;
          w_state_next = HUNT;
        end else if (w_gap_expired) begin
          w_reject     = 1'b1;
          w_state_next = HUNT;
        end
      end
      default: begin
        w_state_next = HUNT;
      end
    endcase
  end

  // Shadow byte capture during PAYLOAD.
  always_ff @(posedge clk) begin
    // NOTE: the shadow bytes are not reset; they are only read after a full
    // frame has rewritten all seven of them.
    if (w_store) begin
      r_shadow[r_idx] <= rx_data;
    end
  end

  // Byte index and running checksum, cleared whenever hunting for sync.
  always_ff @(posedge clk) begin
    if (rst || (r_state == HUNT)) begin
      r_idx <= '0;
      r_xor <= '0;
    end else if (w_store) begin
      r_idx <= r_idx + 1'b1;
      r_xor <= r_xor ^ rx_data;
    end
  end

  // Published fields, status pulses and link level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_ball      <= X_BALL_RST;
      r_y_ball      <= Y_BALL_RST;
      r_y_player    <= Y_PLAYER_RST;
      r_p1_score    <= '0;
      r_p2_score    <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_link_up     <= 1'b0;
    end else begin
      r_frame_valid <= w_accept;
      r_frame_error <= w_reject;
      if (w_accept) begin
        r_x_ball   <= {r_shadow[0][2:0], r_shadow[1]};
        r_y_ball   <= {r_shadow[2][1:0], r_shadow[3]};
        r_y_player <= {r_shadow[4][1:0], r_shadow[5]};
        r_p1_score <= r_shadow[6][7:4];
        r_p2_score <= r_shadow[6][3:0];
        r_link_up  <= 1'b1;
      end else if (w_link_expired) begin
        r_link_up  <= 1'b0;
      end
    end
  end

  assign x_ball        = r_x_ball;
  assign y_ball        = r_y_ball;
  assign y_player      = r_y_player;
  assign player1_score = r_p1_score;
  assign player2_score = r_p2_score;
  assign frame_valid   = r_frame_valid;
  assign frame_error   = r_frame_error;
  assign link_up       = r_link_up;

endmodule
